data_memory_responder: RTL and testbench

//   Bus-side data memory answering the processor's load/store port (address,

---
 rtl/data_memory_responder_if.sv | 28 ++
 rtl/data_memory_responder.sv | 109 ++++++++++
 tb/tb_data_memory_responder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/data_memory_responder_if.sv
// Processor-to-data-memory bus: byte address, level read/write strobes, shared tri-state 64-bit data,
// plus the responder's busy/error status back to the processor.
interface data_memory_responder_if;
  logic [63:0] address;
  logic        read;
  logic        write;
  wire  [63:0] data;
  logic        busy;
  logic        error;

  modport master (
    output address,
    output read,
    output write,
    inout  data,
    input  busy,
    input  error
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    inout  data,
    output busy,
    output error
  );
endinterface

// File: rtl/data_memory_responder.sv
// Data memory behind a tri-state bus: reads answer combinationally, stores post to a coalescing write buffer
// that drains to the array on idle cycles and never stalls the processor. Optional MISALIGN_TRAP_EN adds a sticky alignment fault.
module data_memory_responder #(
  parameter int ADDR_BITS = 10,
  parameter int WB_DEPTH  = 4
) (
  input logic                    clock,
  input logic                    reset,
  data_memory_responder_if.slave bus
);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_BITS-1:0] idx;
    logic [63:0]          dat;
  } wb_ent_t;

  wb_ent_t              ent_q [WB_DEPTH];
  logic [WB_DEPTH-1:0]  vld_q;
  logic [PW-1:0]        head_q, tail_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [63:0]          mem_q [2**ADDR_BITS];

  logic [ADDR_BITS-1:0] idx;
  logic                 fault;
  logic                 rd_cyc, wr_cyc, idle;
  logic                 hit;
  logic [PW-1:0]        hit_slot;
  logic [63:0]          rd_dat;
  logic                 full, drain, enq, upd;

  assign idx = bus.address[ADDR_BITS+2:3];

`ifdef MISALIGN_TRAP_EN
  logic error_q;
  logic unused_addr;
  assign fault       = (bus.read ^ bus.write) & (|bus.address[2:0]);
  assign unused_addr = &{1'b0, bus.address[63:ADDR_BITS+3]};
  assign bus.error   = error_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) error_q <= 1'b0;
    else       error_q <= error_q | fault;
  end
`else
  logic unused_addr;
  assign fault       = 1'b0;
  assign unused_addr = &{1'b0, bus.address[63:ADDR_BITS+3], bus.address[2:0]};
  assign bus.error   = 1'b0;
`endif

  // A faulting access counts as neither a read nor a write, so it also blocks the full-buffer drain.
  assign rd_cyc = bus.read  & ~bus.write & ~fault;
  assign wr_cyc = bus.write & ~bus.read  & ~fault;
  assign idle   = ~bus.read & ~bus.write;

  // Coalescing guarantees at most one live entry per index.
  always_comb begin
    hit      = 1'b0;
    hit_slot = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (vld_q[i] && (ent_q[i].idx == idx)) begin
        hit      = 1'b1;
        hit_slot = PW'(i);
      end
    end
  end

  assign rd_dat   = hit ? ent_q[hit_slot].dat : mem_q[idx];
  assign bus.data = rd_cyc ? rd_dat : 'z;

  assign full  = (cnt_q == CW'(WB_DEPTH));
  assign enq   = wr_cyc & ~hit;
  assign upd   = wr_cyc & hit;
  assign drain = (cnt_q != '0) & (idle | (enq & full));
  assign cnt_d = cnt_q + CW'(enq) - CW'(drain);
  assign bus.busy = (cnt_q != '0);

  // When full, head == tail: the slot is drained and refilled on the same edge, enqueue wins the valid bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (drain) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + 1'b1;
      end
      if (enq) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + 1'b1;
      end
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (enq)      ent_q[tail_q]       <= '{idx: idx, dat: bus.data};
    else if (upd) ent_q[hit_slot].dat <= bus.data;
  end

  // The array is never reset; the drain is gated by count, which reset clears immediately.
  always_ff @(posedge clock) begin
    if (drain) mem_q[ent_q[head_q].idx] <= ent_q[head_q].dat;
  end
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: forwarding, coalescing, full-buffer drain, conflict, async reset, alignment.
// Undriven-bus checks drive a zero probe onto the bus; any responder drive would disturb it.
module tb_data_memory_responder;
  logic        clock;
  logic        reset;
  logic        tb_drv;
  logic [63:0] tb_dat;
  int          n_cmp = 0;
  int          n_err = 0;

  data_memory_responder_if bus ();

  assign bus.data = tb_drv ? tb_dat : 'z;

  data_memory_responder #(.ADDR_BITS(10), .WB_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [63:0] addr,
                       input logic dv, input logic [63:0] dat);
    bus.read    = rd;
    bus.write   = wr;
    bus.address = addr;
    tb_drv      = dv;
    tb_dat      = dat;
  endtask

  task automatic go_idle();
    drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
  endtask

  task automatic wr_word(input logic [63:0] addr, input logic [63:0] val);
    drive(1'b0, 1'b1, addr, 1'b1, val);
    step();
    go_idle();
  endtask

  task automatic rd_chk(input string tag, input logic [63:0] addr, input logic [63:0] exp);
    drive(1'b1, 1'b0, addr, 1'b0, 64'h0);
    #1;
    chk(tag, bus.data, exp);
    step();
    go_idle();
  endtask

  initial begin
    go_idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_busy", {63'h0, bus.busy}, 64'h0);
    chk("rst_error", {63'h0, bus.error}, 64'h0);
    drive(1'b0, 1'b0, 64'h10, 1'b1, 64'h0);
    #1;
    chk("rst_bus_z", bus.data, 64'h0);
    go_idle();

    // T1: forwarded read, then array read after one drain
    wr_word(64'h10, 64'hDEAD_BEEF);
    chk("t1_busy_after_wr", {63'h0, bus.busy}, 64'h1);
    rd_chk("t1_fwd", 64'h10, 64'hDEAD_BEEF);
    chk("t1_busy_after_rd", {63'h0, bus.busy}, 64'h1);
    step();
    chk("t1_busy_drained", {63'h0, bus.busy}, 64'h0);
    rd_chk("t1_array", 64'h10, 64'hDEAD_BEEF);

    // T2: coalescing keeps a single entry
    wr_word(64'h20, 64'h1);
    wr_word(64'h20, 64'h2);
    chk("t2_busy", {63'h0, bus.busy}, 64'h1);
    step();
    chk("t2_one_entry", {63'h0, bus.busy}, 64'h0);
    rd_chk("t2_rd", 64'h20, 64'h2);

    // T3: fifth store into a full buffer drains the head on the same edge
    for (int i = 0; i < 5; i++) wr_word(64'(i * 8), 64'(i + 1));
    chk("t3_busy_full", {63'h0, bus.busy}, 64'h1);
    for (int i = 0; i < 5; i++) rd_chk($sformatf("t3_rd_buf%0d", i), 64'(i * 8), 64'(i + 1));
    step();
    step();
    step();
    chk("t3_busy_3_drains", {63'h0, bus.busy}, 64'h1);
    step();
    chk("t3_busy_4_drains", {63'h0, bus.busy}, 64'h0);
    for (int i = 0; i < 5; i++) rd_chk($sformatf("t3_rd_arr%0d", i), 64'(i * 8), 64'(i + 1));

    // T4: read and write together does nothing
    wr_word(64'h08, 64'h77);
    drive(1'b1, 1'b1, 64'h08, 1'b1, 64'h0);
    #1;
    chk("t4_bus_z", bus.data, 64'h0);
    step();
    go_idle();
    chk("t4_no_drain", {63'h0, bus.busy}, 64'h1);
    step();
    chk("t4_drained", {63'h0, bus.busy}, 64'h0);
    rd_chk("t4_rd", 64'h08, 64'h77);

    // T5: async reset discards pending stores before they drain
    wr_word(64'h00, 64'hAAAA);
    wr_word(64'h10, 64'hBBBB);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_busy_async", {63'h0, bus.busy}, 64'h0);
    step();
    step();
    reset = 1'b0;
    rd_chk("t5_rd00", 64'h00, 64'h1);
    rd_chk("t5_rd10", 64'h10, 64'h3);
    drive(1'b0, 1'b0, 64'h10, 1'b1, 64'h0);
    #1;
    chk("t5_bus_z", bus.data, 64'h0);
    go_idle();

    // upper address bits alias
    rd_chk("alias_b13", 64'h2010, 64'h3);
    rd_chk("alias_b63", 64'h8000_0000_0000_0010, 64'h3);

`ifdef MISALIGN_TRAP_EN
    drive(1'b1, 1'b0, 64'h0C, 1'b1, 64'h0);
    #1;
    chk("t6_bus_z", bus.data, 64'h0);
    chk("t6_err_pre", {63'h0, bus.error}, 64'h0);
    step();
    go_idle();
    chk("t6_err_set", {63'h0, bus.error}, 64'h1);
    wr_word(64'h09, 64'h1234);
    chk("t6_wr_suppressed", {63'h0, bus.busy}, 64'h0);
    rd_chk("t6_rd_valid", 64'h08, 64'h77);
    chk("t6_err_sticky", {63'h0, bus.error}, 64'h1);
    reset = 1'b1;
    #1;
    chk("t6_err_cleared", {63'h0, bus.error}, 64'h0);
    step();
    reset = 1'b0;
`else
    rd_chk("t6_rd_unaligned", 64'h0C, 64'h77);
    chk("t6_err_tied", {63'h0, bus.error}, 64'h0);
    wr_word(64'h09, 64'h1234);
    chk("t6_wr_busy", {63'h0, bus.busy}, 64'h1);
    step();
    rd_chk("t6_rd_after_wr", 64'h08, 64'h1234);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
